// File: rtl/agu_store_queue_pkg.sv
// ============================================================================
// Module      : agu_store_queue_pkg
// Description : Shared size encodings, trap code and default widths for the
//               store address-generation queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package agu_store_queue_pkg;

    localparam int DEF_NUM_BYP = 5;
    localparam int DEF_DATA_W  = 32;
    localparam int DEF_PREG_W  = 7;
    localparam int DEF_ROB_W   = 6;
    localparam int DEF_DEPTH   = 4;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;
    localparam logic [1:0] SIZE_RSVD = 2'd3;

    localparam logic [6:0] MISALIGN_CODE = 7'h09;

    // The reserved size encoding is treated as a misaligned access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return offset[0];
            SIZE_WORD: return |offset;
            default:   return 1'b1;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/agu_bypass_mux.sv
// ============================================================================
// Module      : agu_bypass_mux
// Description : Operand forwarding; lowest-index matching bypass channel wins,
//               otherwise the register-file value is used.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module agu_bypass_mux #(
    parameter int NUM_BYP = 5,
    parameter int PREG_W  = 7,
    parameter int DATA_W  = 32
) (
    input  logic                        i_src_able,
    input  logic [PREG_W-1:0]           i_src_tag,
    input  logic [DATA_W-1:0]           i_src_data,
    input  logic [NUM_BYP-1:0]          i_byp_able,
    input  logic [NUM_BYP*PREG_W-1:0]   i_byp_tag,
    input  logic [NUM_BYP*DATA_W-1:0]   i_byp_data,
    output logic [DATA_W-1:0]           o_data
);

    // Scan from the highest index down so the lowest match is applied last.
    always_comb begin
        o_data = i_src_data;
        for (int i = NUM_BYP - 1; i >= 0; i--) begin
            if (i_src_able && i_byp_able[i] &&
                (i_byp_tag[i*PREG_W +: PREG_W] == i_src_tag)) begin
                o_data = i_byp_data[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/agu_store_queue.sv
// ============================================================================
// Module      : agu_store_queue
// Description : Store AGU: forwarding, address generation, one MMU stage (S1)
//               and an output FIFO feeding the store buffer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module agu_store_queue
    import agu_store_queue_pkg::*;
#(
    parameter int NUM_BYP = DEF_NUM_BYP,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PREG_W  = DEF_PREG_W,
    parameter int ROB_W   = DEF_ROB_W,
    parameter int DEPTH   = DEF_DEPTH
) (
    input  logic                        Clk,
    input  logic                        Rest,
    input  logic                        Flush,
    input  logic                        IssValid,
    output logic                        IssReady,
    input  logic [7:0]                  IssMicOp,
    input  logic [1:0]                  IssSize,
    input  logic                        IssSrcAble0,
    input  logic                        IssSrcAble1,
    input  logic [PREG_W-1:0]           IssSrcAddr0,
    input  logic [PREG_W-1:0]           IssSrcAddr1,
    input  logic [DATA_W-1:0]           IssSrcDate0,
    input  logic [DATA_W-1:0]           IssSrcDate1,
    input  logic [11:0]                 IssImm,
    input  logic                        IssWbAble,
    input  logic [PREG_W-1:0]           IssWbAddr,
    input  logic [ROB_W-1:0]            IssRobPtr,
    input  logic [NUM_BYP-1:0]          BypAble,
    input  logic [NUM_BYP*PREG_W-1:0]   BypAddr,
    input  logic [NUM_BYP*DATA_W-1:0]   BypDate,
    output logic                        MmuAccess,
    output logic [DATA_W-1:0]           MmuVAddr,
    input  logic [1:0]                  MmuMAT,
    input  logic                        MmuTrap,
    input  logic [6:0]                  MmuTrapCode,
    input  logic [DATA_W-1:0]           MmuPAddr,
    output logic                        SbValid,
    input  logic                        SbReady,
    output logic [7:0]                  SbMicOp,
    output logic [DATA_W-1:0]           SbWDate,
    output logic [DATA_W/8-1:0]         SbMask,
    output logic [1:0]                  SbMAT,
    output logic [DATA_W-1:0]           SbPAddr,
    output logic                        SbTrap,
    output logic [6:0]                  SbTrapCode,
    output logic                        SbWbAble,
    output logic [PREG_W-1:0]           SbWbAddr,
    output logic [ROB_W-1:0]            SbRobPtr
);

    localparam int MASK_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [DATA_W-1:0] w_src0;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_vaddr;
    logic [1:0]        w_offset;
    logic              w_accept;
    logic              w_misalign;
    logic [MASK_W-1:0] w_mask;
    logic [DATA_W-1:0] w_wdata;

    agu_bypass_mux #(.NUM_BYP(NUM_BYP), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_byp_src0 (
        .i_src_able (IssSrcAble0),
        .i_src_tag  (IssSrcAddr0),
        .i_src_data (IssSrcDate0),
        .i_byp_able (BypAble),
        .i_byp_tag  (BypAddr),
        .i_byp_data (BypDate),
        .o_data     (w_src0)
    );

    agu_bypass_mux #(.NUM_BYP(NUM_BYP), .PREG_W(PREG_W), .DATA_W(DATA_W)) u_byp_src1 (
        .i_src_able (IssSrcAble1),
        .i_src_tag  (IssSrcAddr1),
        .i_src_data (IssSrcDate1),
        .i_byp_able (BypAble),
        .i_byp_tag  (BypAddr),
        .i_byp_data (BypDate),
        .o_data     (w_src1)
    );

    // ---------------- issue stage ----------------
    logic              s1_valid_q, s1_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;

    assign w_vaddr   = w_src0 + {{(DATA_W-12){IssImm[11]}}, IssImm};
    assign w_offset  = w_vaddr[1:0];
    assign IssReady  = ((count_q + {{(CNT_W-1){1'b0}}, s1_valid_q}) < DEPTH_C) & ~Rest;
    assign w_accept  = IssValid & IssReady & ~Flush;
    assign MmuAccess = w_accept;
    assign MmuVAddr  = w_vaddr;
    assign w_misalign = is_misaligned(IssSize, w_offset);

    always_comb begin
        w_mask  = {MASK_W{1'b1}};
        w_wdata = w_src1;
        case (IssSize)
            SIZE_BYTE: begin
                w_mask  = MASK_W'(1) << w_offset;
                w_wdata = w_src1 << {w_offset, 3'b000};
            end
            SIZE_HALF: begin
                w_mask  = MASK_W'(3) << w_offset;
                w_wdata = w_src1 << {w_offset, 3'b000};
            end
            default: ;
        endcase
    end

    // ---------------- S1: waits for the MMU response ----------------
    logic [7:0]        s1_micop_q,    s1_micop_d;
    logic [DATA_W-1:0] s1_wdata_q,    s1_wdata_d;
    logic [MASK_W-1:0] s1_mask_q,     s1_mask_d;
    logic              s1_misalign_q, s1_misalign_d;
    logic              s1_wb_able_q,  s1_wb_able_d;
    logic [PREG_W-1:0] s1_wb_addr_q,  s1_wb_addr_d;
    logic [ROB_W-1:0]  s1_rob_q,      s1_rob_d;

    always_comb begin
        s1_valid_d    = w_accept;
        s1_micop_d    = s1_micop_q;
        s1_wdata_d    = s1_wdata_q;
        s1_mask_d     = s1_mask_q;
        s1_misalign_d = s1_misalign_q;
        s1_wb_able_d  = s1_wb_able_q;
        s1_wb_addr_d  = s1_wb_addr_q;
        s1_rob_d      = s1_rob_q;
        if (w_accept) begin
            s1_micop_d    = IssMicOp;
            s1_wdata_d    = w_wdata;
            s1_mask_d     = w_mask;
            s1_misalign_d = w_misalign;
            s1_wb_able_d  = IssWbAble;
            s1_wb_addr_d  = IssWbAddr;
            s1_rob_d      = IssRobPtr;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            s1_valid_q    <= 1'b0;
            s1_micop_q    <= '0;
            s1_wdata_q    <= '0;
            s1_mask_q     <= '0;
            s1_misalign_q <= 1'b0;
            s1_wb_able_q  <= 1'b0;
            s1_wb_addr_q  <= '0;
            s1_rob_q      <= '0;
        end else begin
            s1_valid_q    <= s1_valid_d;
            s1_micop_q    <= s1_micop_d;
            s1_wdata_q    <= s1_wdata_d;
            s1_mask_q     <= s1_mask_d;
            s1_misalign_q <= s1_misalign_d;
            s1_wb_able_q  <= s1_wb_able_d;
            s1_wb_addr_q  <= s1_wb_addr_d;
            s1_rob_q      <= s1_rob_d;
        end
    end

    // ---------------- output FIFO ----------------
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic              w_enq;
    logic              w_deq;
    logic              w_sb_valid;

    logic              ent_trap_d;
    logic [6:0]        ent_code_d;
    logic [MASK_W-1:0] ent_mask_d;

    logic [7:0]        fifo_micop_q [DEPTH];
    logic [DATA_W-1:0] fifo_wdata_q [DEPTH];
    logic [MASK_W-1:0] fifo_mask_q  [DEPTH];
    logic [1:0]        fifo_mat_q   [DEPTH];
    logic [DATA_W-1:0] fifo_paddr_q [DEPTH];
    logic              fifo_trap_q  [DEPTH];
    logic [6:0]        fifo_code_q  [DEPTH];
    logic              fifo_wba_q   [DEPTH];
    logic [PREG_W-1:0] fifo_wbt_q   [DEPTH];
    logic [ROB_W-1:0]  fifo_rob_q   [DEPTH];

    // Flush drops the S1 write and any dequeue in the same cycle.
    assign w_sb_valid = (count_q != '0) & ~Rest;
    assign w_enq      = s1_valid_q & ~Flush & ~Rest;
    assign w_deq      = w_sb_valid & SbReady & ~Flush;

    // Misalignment outranks a TLB fault; any trapping store writes no bytes.
    always_comb begin
        ent_trap_d = s1_misalign_q | MmuTrap;
        ent_code_d = s1_misalign_q ? MISALIGN_CODE : MmuTrapCode;
        ent_mask_d = ent_trap_d ? '0 : s1_mask_q;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (Flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (w_enq) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (w_deq) rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d = count_q + {{(CNT_W-1){1'b0}}, w_enq} - {{(CNT_W-1){1'b0}}, w_deq};
        end
    end

    always_ff @(posedge Clk) begin
        if (Rest) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (w_enq) begin
            fifo_micop_q[wr_ptr_q] <= s1_micop_q;
            fifo_wdata_q[wr_ptr_q] <= s1_wdata_q;
            fifo_mask_q[wr_ptr_q]  <= ent_mask_d;
            fifo_mat_q[wr_ptr_q]   <= MmuMAT;
            fifo_paddr_q[wr_ptr_q] <= MmuPAddr;
            fifo_trap_q[wr_ptr_q]  <= ent_trap_d;
            fifo_code_q[wr_ptr_q]  <= ent_code_d;
            fifo_wba_q[wr_ptr_q]   <= s1_wb_able_q;
            fifo_wbt_q[wr_ptr_q]   <= s1_wb_addr_q;
            fifo_rob_q[wr_ptr_q]   <= s1_rob_q;
        end
    end

    always_comb begin
        SbValid    = w_sb_valid;
        SbMicOp    = '0;
        SbWDate    = '0;
        SbMask     = '0;
        SbMAT      = '0;
        SbPAddr    = '0;
        SbTrap     = 1'b0;
        SbTrapCode = '0;
        SbWbAble   = 1'b0;
        SbWbAddr   = '0;
        SbRobPtr   = '0;
        if (w_sb_valid) begin
            SbMicOp    = fifo_micop_q[rd_ptr_q];
            SbWDate    = fifo_wdata_q[rd_ptr_q];
            SbMask     = fifo_mask_q[rd_ptr_q];
            SbMAT      = fifo_mat_q[rd_ptr_q];
            SbPAddr    = fifo_paddr_q[rd_ptr_q];
            SbTrap     = fifo_trap_q[rd_ptr_q];
            SbTrapCode = fifo_code_q[rd_ptr_q];
            SbWbAble   = fifo_wba_q[rd_ptr_q];
            SbWbAddr   = fifo_wbt_q[rd_ptr_q];
            SbRobPtr   = fifo_rob_q[rd_ptr_q];
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_agu_store_queue.sv
// ============================================================================
// Module      : tb_agu_store_queue
// Description : Directed self-checking bench for agu_store_queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_agu_store_queue;

    logic        Clk = 1'b0;
    logic        Rest, Flush, IssValid, IssReady;
    logic [7:0]  IssMicOp;
    logic [1:0]  IssSize;
    logic        IssSrcAble0, IssSrcAble1;
    logic [6:0]  IssSrcAddr0, IssSrcAddr1;
    logic [31:0] IssSrcDate0, IssSrcDate1;
    logic [11:0] IssImm;
    logic        IssWbAble;
    logic [6:0]  IssWbAddr;
    logic [5:0]  IssRobPtr;
    logic [4:0]  BypAble;
    logic [34:0] BypAddr;
    logic [159:0] BypDate;
    logic        MmuAccess;
    logic [31:0] MmuVAddr;
    logic [1:0]  MmuMAT;
    logic        MmuTrap;
    logic [6:0]  MmuTrapCode;
    logic [31:0] MmuPAddr;
    logic        SbValid, SbReady;
    logic [7:0]  SbMicOp;
    logic [31:0] SbWDate;
    logic [3:0]  SbMask;
    logic [1:0]  SbMAT;
    logic [31:0] SbPAddr;
    logic        SbTrap;
    logic [6:0]  SbTrapCode;
    logic        SbWbAble;
    logic [6:0]  SbWbAddr;
    logic [5:0]  SbRobPtr;

    int n_cmp = 0;
    int n_err = 0;

    agu_store_queue dut (
        .Clk(Clk), .Rest(Rest), .Flush(Flush),
        .IssValid(IssValid), .IssReady(IssReady), .IssMicOp(IssMicOp), .IssSize(IssSize),
        .IssSrcAble0(IssSrcAble0), .IssSrcAble1(IssSrcAble1),
        .IssSrcAddr0(IssSrcAddr0), .IssSrcAddr1(IssSrcAddr1),
        .IssSrcDate0(IssSrcDate0), .IssSrcDate1(IssSrcDate1),
        .IssImm(IssImm), .IssWbAble(IssWbAble), .IssWbAddr(IssWbAddr), .IssRobPtr(IssRobPtr),
        .BypAble(BypAble), .BypAddr(BypAddr), .BypDate(BypDate),
        .MmuAccess(MmuAccess), .MmuVAddr(MmuVAddr), .MmuMAT(MmuMAT), .MmuTrap(MmuTrap),
        .MmuTrapCode(MmuTrapCode), .MmuPAddr(MmuPAddr),
        .SbValid(SbValid), .SbReady(SbReady), .SbMicOp(SbMicOp), .SbWDate(SbWDate),
        .SbMask(SbMask), .SbMAT(SbMAT), .SbPAddr(SbPAddr), .SbTrap(SbTrap),
        .SbTrapCode(SbTrapCode), .SbWbAble(SbWbAble), .SbWbAddr(SbWbAddr), .SbRobPtr(SbRobPtr)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Drives one issue cycle; the MMU response for it is presented in the next cycle.
    task automatic issue(input logic [7:0] mop, input logic [1:0] sz, input logic [31:0] s0,
                         input logic [11:0] imm, input logic [31:0] s1, input logic [1:0] mat,
                         input logic tr, input logic [6:0] code, input logic [31:0] pa,
                         output logic acc);
        IssValid = 1'b1; IssMicOp = mop; IssSize = sz; IssSrcDate0 = s0; IssImm = imm;
        IssSrcDate1 = s1; IssWbAble = 1'b1; IssWbAddr = mop[6:0]; IssRobPtr = mop[5:0];
        #1 acc = IssReady;
        @(posedge Clk);
        #1;
        IssValid = 1'b0; MmuMAT = mat; MmuTrap = tr; MmuTrapCode = code; MmuPAddr = pa;
    endtask

    task automatic pop();
        SbReady = 1'b1;
        tick();
        SbReady = 1'b0;
    endtask

    task automatic test_reset();
        Rest = 1'b1; IssValid = 1'b1;
        tick(); tick();
        n_cmp++; if (IssReady !== 1'b0) begin n_err++; $display("FAIL reset_issready: got %b want 0", IssReady); end
        n_cmp++; if (MmuAccess !== 1'b0) begin n_err++; $display("FAIL reset_mmuaccess: got %b want 0", MmuAccess); end
        n_cmp++; if ({SbValid, SbWDate, SbMask, SbTrap} !== '0) begin n_err++; $display("FAIL reset_sb: got %b/%h/%b/%b want 0", SbValid, SbWDate, SbMask, SbTrap); end
        IssValid = 1'b0; Rest = 1'b0;
        tick();
        n_cmp++; if (IssReady !== 1'b1) begin n_err++; $display("FAIL post_reset_ready: got %b want 1", IssReady); end
        n_cmp++; if (SbValid !== 1'b0) begin n_err++; $display("FAIL post_reset_sbvalid: got %b want 0", SbValid); end
    endtask

    task automatic test_bypass();
        IssSrcAble0 = 1'b1; IssSrcAddr0 = 7'd5; IssSrcDate0 = 32'h99; IssImm = 12'h004;
        BypAble = 5'b01010;
        BypAddr = '0; BypAddr[7 +: 7] = 7'd5; BypAddr[21 +: 7] = 7'd5;
        BypDate = '0; BypDate[32 +: 32] = 32'h10; BypDate[96 +: 32] = 32'h20;
        #1;
        n_cmp++; if (MmuVAddr !== 32'h14) begin n_err++; $display("FAIL bypass_lowest: got %h want 00000014", MmuVAddr); end
        BypAble = 5'b01000; #1;
        n_cmp++; if (MmuVAddr !== 32'h24) begin n_err++; $display("FAIL bypass_ch3: got %h want 00000024", MmuVAddr); end
        IssSrcAble0 = 1'b0; #1;
        n_cmp++; if (MmuVAddr !== 32'h9D) begin n_err++; $display("FAIL bypass_srcable0: got %h want 0000009d", MmuVAddr); end
        IssSrcAble0 = 1'b1; IssSrcAddr0 = 7'd6; BypAble = 5'b11111; #1;
        n_cmp++; if (MmuVAddr !== 32'h9D) begin n_err++; $display("FAIL bypass_nomatch: got %h want 0000009d", MmuVAddr); end
        IssSrcAble0 = 1'b0; BypAble = '0;
    endtask

    task automatic test_imm_sign();
        IssSrcDate0 = 32'h0000_0100; IssImm = 12'h800; #1;
        n_cmp++; if (MmuVAddr !== 32'hFFFF_F900) begin n_err++; $display("FAIL imm_sign: got %h want fffff900", MmuVAddr); end
        IssImm = 12'h7FF; #1;
        n_cmp++; if (MmuVAddr !== 32'h0000_08FF) begin n_err++; $display("FAIL imm_pos: got %h want 000008ff", MmuVAddr); end
    endtask

    task automatic test_half_store();
        logic acc;
        IssSrcDate0 = 32'h1000; IssImm = 12'h002; IssValid = 1'b1; IssSize = 2'd1; #1;
        n_cmp++; if (MmuAccess !== 1'b1) begin n_err++; $display("FAIL half_mmuaccess: got %b want 1", MmuAccess); end
        issue(8'h5A, 2'd1, 32'h1000, 12'h002, 32'h0000_ABCD, 2'd2, 1'b0, 7'h00, 32'h8000_1002, acc);
        tick();
        n_cmp++; if (SbValid !== 1'b1) begin n_err++; $display("FAIL half_valid_latency2: got %b want 1", SbValid); end
        n_cmp++; if (SbMask !== 4'b1100) begin n_err++; $display("FAIL half_mask: got %b want 1100", SbMask); end
        n_cmp++; if (SbWDate !== 32'hABCD_0000) begin n_err++; $display("FAIL half_wdata: got %h want abcd0000", SbWDate); end
        n_cmp++; if (SbTrap !== 1'b0) begin n_err++; $display("FAIL half_trap: got %b want 0", SbTrap); end
        n_cmp++; if ({SbPAddr, SbMAT} !== {32'h8000_1002, 2'd2}) begin n_err++; $display("FAIL half_mmu: got %h/%0d want 80001002/2", SbPAddr, SbMAT); end
        n_cmp++; if ({SbMicOp, SbWbAble, SbWbAddr, SbRobPtr} !== {8'h5A, 1'b1, 7'h5A, 6'h1A}) begin
            n_err++; $display("FAIL half_tags: got %h/%b/%h/%h want 5a/1/5a/1a", SbMicOp, SbWbAble, SbWbAddr, SbRobPtr); end
        pop();
        n_cmp++; if ({SbValid, SbPAddr, SbWDate} !== '0) begin n_err++; $display("FAIL empty_zero: got %b/%h/%h want 0", SbValid, SbPAddr, SbWDate); end
    endtask

    task automatic test_byte_store();
        logic acc;
        issue(8'h11, 2'd0, 32'h2000, 12'h003, 32'h0000_00EE, 2'd1, 1'b0, 7'h00, 32'h2003, acc);
        tick();
        n_cmp++; if ({SbMask, SbWDate} !== {4'b1000, 32'hEE00_0000}) begin n_err++; $display("FAIL byte_lane: got %b/%h want 1000/ee000000", SbMask, SbWDate); end
        pop();
    endtask

    task automatic test_traps();
        logic acc;
        issue(8'h21, 2'd2, 32'h1000, 12'h001, 32'h1, 2'd0, 1'b1, 7'h3F, 32'h0, acc);
        tick();
        n_cmp++; if ({SbTrap, SbTrapCode, SbMask} !== {1'b1, 7'h09, 4'b0000}) begin
            n_err++; $display("FAIL misalign_over_tlb: got %b/%h/%b want 1/09/0000", SbTrap, SbTrapCode, SbMask); end
        pop();
        issue(8'h22, 2'd2, 32'h1000, 12'h004, 32'h1, 2'd0, 1'b1, 7'h3F, 32'h0, acc);
        tick();
        n_cmp++; if ({SbTrap, SbTrapCode, SbMask} !== {1'b1, 7'h3F, 4'b0000}) begin
            n_err++; $display("FAIL tlb_trap: got %b/%h/%b want 1/3f/0000", SbTrap, SbTrapCode, SbMask); end
        pop();
        issue(8'h23, 2'd3, 32'h1000, 12'h000, 32'h1, 2'd0, 1'b0, 7'h00, 32'h0, acc);
        tick();
        n_cmp++; if ({SbTrap, SbTrapCode, SbMask} !== {1'b1, 7'h09, 4'b0000}) begin
            n_err++; $display("FAIL size3_trap: got %b/%h/%b want 1/09/0000", SbTrap, SbTrapCode, SbMask); end
        pop();
        issue(8'h24, 2'd1, 32'h1000, 12'h003, 32'h1, 2'd0, 1'b0, 7'h00, 32'h0, acc);
        tick();
        n_cmp++; if ({SbTrap, SbTrapCode} !== {1'b1, 7'h09}) begin n_err++; $display("FAIL half_odd_trap: got %b/%h want 1/09", SbTrap, SbTrapCode); end
        pop();
        MmuTrap = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic acc;
        SbReady = 1'b0;
        for (int k = 0; k < 6; k++) begin
            issue(8'h20 + 8'(k), 2'd2, 32'h3000, 12'(k * 4), 32'h1111_0000 + 32'(k),
                  2'd0, 1'b0, 7'h00, 32'h9000_0000 + 32'(k * 4), acc);
            n_cmp++; if (acc !== (k < 4)) begin n_err++; $display("FAIL b2b_accept_%0d: got %b want %b", k, acc, (k < 4)); end
        end
        n_cmp++; if ({IssReady, SbValid} !== 2'b01) begin n_err++; $display("FAIL b2b_full: got ready=%b valid=%b want 0/1", IssReady, SbValid); end
        SbReady = 1'b1;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({SbValid, SbWDate, SbPAddr, SbMask} !== {1'b1, 32'h1111_0000 + 32'(i), 32'h9000_0000 + 32'(i * 4), 4'hF}) begin
                n_err++; $display("FAIL b2b_order_%0d: got %b/%h/%h/%b want 1/%h/%h/1111", i, SbValid, SbWDate, SbPAddr, SbMask,
                                  32'h1111_0000 + 32'(i), 32'h9000_0000 + 32'(i * 4));
            end
            tick();
        end
        SbReady = 1'b0;
        n_cmp++; if ({IssReady, SbValid} !== 2'b10) begin n_err++; $display("FAIL b2b_drained: got ready=%b valid=%b want 1/0", IssReady, SbValid); end
    endtask

    task automatic test_flush();
        logic acc;
        IssValid = 1'b1; IssSize = 2'd2; IssImm = 12'h0; Flush = 1'b1; #1;
        n_cmp++; if (MmuAccess !== 1'b0) begin n_err++; $display("FAIL flush_block_accept: got %b want 0", MmuAccess); end
        tick();
        IssValid = 1'b0; Flush = 1'b0;
        tick();
        n_cmp++; if (SbValid !== 1'b0) begin n_err++; $display("FAIL flush_no_entry: got %b want 0", SbValid); end
        for (int k = 0; k < 4; k++)
            issue(8'h40 + 8'(k), 2'd2, 32'h4000, 12'h0, 32'h5500 + 32'(k), 2'd0, 1'b0, 7'h00, 32'h4000, acc);
        Flush = 1'b1; SbReady = 1'b1;
        tick();
        Flush = 1'b0; SbReady = 1'b0; MmuPAddr = 32'hDEAD_0000;
        n_cmp++; if (SbValid !== 1'b0) begin n_err++; $display("FAIL flush_empty: got %b want 0", SbValid); end
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (SbValid !== 1'b0) begin n_err++; $display("FAIL flush_stale_%0d: got %b want 0", k, SbValid); end
        end
        n_cmp++; if (IssReady !== 1'b1) begin n_err++; $display("FAIL flush_ready: got %b want 1", IssReady); end
        issue(8'h77, 2'd2, 32'h4000, 12'h0, 32'h1234_5678, 2'd0, 1'b0, 7'h00, 32'h4000, acc);
        tick();
        n_cmp++; if ({SbValid, SbWDate, SbMicOp} !== {1'b1, 32'h1234_5678, 8'h77}) begin
            n_err++; $display("FAIL flush_restart: got %b/%h/%h want 1/12345678/77", SbValid, SbWDate, SbMicOp); end
        pop();
        n_cmp++; if (SbValid !== 1'b0) begin n_err++; $display("FAIL flush_restart_pop: got %b want 0", SbValid); end
    endtask

    task automatic test_mid_reset();
        logic acc;
        issue(8'h61, 2'd2, 32'h6000, 12'h0, 32'hCAFE_0001, 2'd0, 1'b0, 7'h00, 32'h6000, acc);
        issue(8'h62, 2'd2, 32'h6000, 12'h0, 32'hCAFE_0002, 2'd0, 1'b0, 7'h00, 32'h6000, acc);
        Rest = 1'b1; IssValid = 1'b1; #1;
        n_cmp++; if ({SbValid, SbWDate, SbMask, IssReady, MmuAccess} !== '0) begin
            n_err++; $display("FAIL rest_assert: got %b/%h/%b/%b/%b want 0", SbValid, SbWDate, SbMask, IssReady, MmuAccess); end
        tick();
        n_cmp++; if ({SbValid, SbPAddr, IssReady, MmuAccess} !== '0) begin
            n_err++; $display("FAIL rest_held: got %b/%h/%b/%b want 0", SbValid, SbPAddr, IssReady, MmuAccess); end
        Rest = 1'b0; IssValid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_cmp++; if (SbValid !== 1'b0) begin n_err++; $display("FAIL rest_discard_%0d: got %b want 0", k, SbValid); end
        end
        n_cmp++; if (IssReady !== 1'b1) begin n_err++; $display("FAIL rest_release_ready: got %b want 1", IssReady); end
    endtask

    initial begin
        Rest = 1'b1; Flush = 1'b0; IssValid = 1'b0; IssMicOp = '0; IssSize = '0;
        IssSrcAble0 = 1'b0; IssSrcAble1 = 1'b0; IssSrcAddr0 = '0; IssSrcAddr1 = '0;
        IssSrcDate0 = '0; IssSrcDate1 = '0; IssImm = '0; IssWbAble = 1'b0; IssWbAddr = '0;
        IssRobPtr = '0; BypAble = '0; BypAddr = '0; BypDate = '0;
        MmuMAT = '0; MmuTrap = 1'b0; MmuTrapCode = '0; MmuPAddr = '0; SbReady = 1'b0;
        test_reset();
        test_bypass();
        test_imm_sign();
        test_half_store();
        test_byte_store();
        test_traps();
        test_back_to_back();
        test_flush();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/agu_store_queue.md
AGU_STORE_QUEUE -- requirements
Module: agu_store_queue

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- NUM_BYP, 5: bypass channels
- DATA_W, 32: data/address width
- PREG_W, 7: rename-register tag width
- ROB_W, 6: ROB pointer width
- DEPTH, 4: output FIFO entries, power of two, at least 2
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- Clk, in, 1: clock
- Rest, in, 1: synchronous, active-high reset
- Flush, in, 1: pipeline flush
- IssValid, in, 1: store issued
- IssReady, out, 1: store accepted
- IssMicOp, in, 8: micro-op
- IssSize, in, 2: 0 byte, 1 half, 2 word, 3 reserved
- IssSrcAble0 and IssSrcAble1, in, 1 each: source valid
- IssSrcAddr0 and IssSrcAddr1, in, PREG_W each: source tag
- IssSrcDate0 and IssSrcDate1, in, DATA_W each: regfile value
- IssImm, in, 12: signed offset
- IssWbAble, in, 1: writeback valid
- IssWbAddr, in, PREG_W: writeback tag
- IssRobPtr, in, ROB_W: ROB pointer
- BypAble, in, NUM_BYP: bypass valid per channel
- BypAddr, in, NUM_BYP*PREG_W: bypass tags, channel i at slice i
- BypDate, in, NUM_BYP*DATA_W: bypass data
- MmuAccess, out, 1: translation request
- MmuVAddr, out, DATA_W: virtual address
- MmuMAT, in, 2: memory access type, one cycle after request
- MmuTrap, in, 1: TLB exception, one cycle after request
- MmuTrapCode, in, 7: TLB exception code
- MmuPAddr, in, DATA_W: physical address
- SbValid, out, 1: store-buffer entry valid
- SbReady, in, 1: store buffer accepts
- SbMicOp, out, 8: micro-op
- SbWDate, out, DATA_W: lane-aligned store data
- SbMask, out, DATA_W/8: byte enables
- SbMAT, out, 2: memory access type
- SbPAddr, out, DATA_W: physical address
- SbTrap, out, 1: exception flag
- SbTrapCode, out, 7: exception code
- SbWbAble, out, 1: writeback valid
- SbWbAddr, out, PREG_W: writeback tag
- SbRobPtr, out, ROB_W: ROB pointer

Function
REQ-003 Operand forwarding SHALL pick, per source, the lowest-index channel i with BypAble[i], IssSrcAble, and matching tag; with no match, or IssSrcAble low, it SHALL use IssSrcDate.
REQ-004 MmuVAddr SHALL equal forwarded src0 plus sign-extended IssImm, modulo 2^DATA_W; MmuAccess SHALL equal IssValid & IssReady & !Flush.
REQ-005 An accepted store SHALL load stage S1 the next cycle; S1 SHALL capture MmuMAT, MmuTrap, MmuTrapCode and MmuPAddr during its single valid cycle and write into the FIFO at the end of that cycle.
REQ-006 IssReady SHALL equal (FifoCount + S1Valid < DEPTH) & !Rest, which guarantees that S1 never stalls.
REQ-007 Misalignment SHALL be raised when a half access has VA[0]=1, or a word access has VA[1:0]!=0, or IssSize=3; the store SHALL then carry SbTrap=1 and SbTrapCode=7'h09.
REQ-008 Trap priority: misalignment over TLB; an entry with SbTrap=1 SHALL have SbMask=0.
REQ-009 Data alignment: src1 data SHALL be shifted left by 8*VA[1:0] bits for byte and half accesses.
REQ-010 SbMask values: byte 4'b0001<<VA[1:0]; half 4'b0011<<VA[1:0]; word 4'b1111.
REQ-011 The FIFO head SHALL drive the Sb* outputs; it dequeues when SbValid & SbReady; minimum issue-to-SbValid latency is 2 cycles.
REQ-012 A simultaneous enqueue and dequeue SHALL leave FifoCount unchanged, including at full; pointers wrap modulo DEPTH.
REQ-013 When the FIFO is empty, SbValid=0 and all other Sb* outputs SHALL be 0.
REQ-014 Flush SHALL clear S1, the FIFO pointers and FifoCount in the same cycle, block acceptance that cycle, and discard any MMU response arriving the following cycle.
REQ-015 Flush and SbReady asserted together: no dequeue is reported and the FIFO empties.

Reset
REQ-016 While Rest is high, S1Valid=0, FifoCount=0, pointers=0, IssReady=0, MmuAccess=0, and all Sb* outputs=0.
REQ-017 Rest asserted mid-operation SHALL discard all in-flight stores with no partial output.

Structure
REQ-018 A shared package SHALL hold the size encodings, the misalign code 7'h09 and the default parameter widths.
REQ-019 Forwarding SHALL be a sub-module, agu_bypass_mux, parametrised by NUM_BYP, PREG_W and DATA_W, instantiated once per source.

Verification
REQ-020 Bypass: channels 1 and 3 both match src0 with BypDate 0x10 and 0x20, regfile 0x99, imm 0x004 -> MmuVAddr 0x14.
REQ-021 Half store, VA 0x1002, src1 0xABCD -> SbMask 4'b1100, SbWDate 0xABCD0000, SbTrap 0.
REQ-022 Word store, VA 0x1001, with MmuTrap=1 and code 0x3F -> SbTrap 1, SbTrapCode 0x09, SbMask 0.
REQ-023 SbReady held low and stores issued back-to-back -> IssReady drops after 4 accepted (DEPTH=4); SbReady high -> order preserved and IssReady reasserts.
REQ-024 Flush with 3 entries queued plus S1 valid -> SbValid 0 the next cycle and no later output from those stores.
REQ-025 Imm 0x800 with src0 0x00000100 -> MmuVAddr 0xFFFFF900; Rest pulsed mid-stream -> all outputs 0 and IssReady 0 during reset.
